// File: rtl/axi_add_arb_if.sv
// Bundles the two requester channels, the result channel and the lock flag of the adder arbiter.
// The arbiter uses slave; a driver or bench acting as both requesters and the sink uses master.
interface axi_add_arb_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] s0_a;
  logic [WIDTH-1:0] s0_b;
  logic             s0_valid;
  logic             s0_last;
  logic             s0_ready;

  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_valid;
  logic             s1_last;
  logic             s1_ready;

  logic [WIDTH:0]   dout;
  logic             dout_id;
  logic             dout_last;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;

  modport slave (
    input  s0_a, s0_b, s0_valid, s0_last,
    output s0_ready,
    input  s1_a, s1_b, s1_valid, s1_last,
    output s1_ready,
    output dout, dout_id, dout_last, dout_valid,
    input  dout_ready,
    output busy
  );

  modport master (
    output s0_a, s0_b, s0_valid, s0_last,
    input  s0_ready,
    output s1_a, s1_b, s1_valid, s1_last,
    input  s1_ready,
    input  dout, dout_id, dout_last, dout_valid,
    output dout_ready,
    input  busy
  );
endinterface

// File: rtl/axi_add_arb.sv
// Two-requester round-robin arbiter with burst lock feeding a registered adder; 1-cycle latency.
// Backpressure: both readies stay low while a result is held unconsumed on dout.
module axi_add_arb #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  axi_add_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH:0] sum;
    logic           id;
    logic           last;
  } beat_t;

  state_t         state;
  logic           rr;
  logic           busy_q;
  logic [WIDTH:0] dout_q;
  logic           dout_id_q;
  logic           dout_last_q;
  logic           dout_valid_q;

  // While reset is held the readies already reflect the post-reset state.
  state_t state_eff;
  logic   rr_eff;
  logic   dout_valid_eff;
  logic   out_free;
  logic   gnt0;
  logic   gnt1;
  logic   hs0;
  logic   hs1;
  beat_t  sel;

  assign state_eff      = rst_n ? state : IDLE;
  assign rr_eff         = rst_n ? rr : 1'b1;
  assign dout_valid_eff = rst_n & dout_valid_q;
  assign out_free       = !dout_valid_eff || bus.dout_ready;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (out_free) begin
      case (state_eff)
        IDLE: begin
          if (bus.s0_valid && !bus.s1_valid) begin
            gnt0 = 1'b1;
          end else if (bus.s1_valid && !bus.s0_valid) begin
            gnt1 = 1'b1;
          end else if (bus.s0_valid && bus.s1_valid) begin
            gnt0 = rr_eff;
            gnt1 = !rr_eff;
          end
        end
        LOCK0:   gnt0 = 1'b1;
        LOCK1:   gnt1 = 1'b1;
        default: begin
          gnt0 = 1'b0;
          gnt1 = 1'b0;
        end
      endcase
    end
  end

  assign bus.s0_ready = gnt0;
  assign bus.s1_ready = gnt1;
  assign hs0          = bus.s0_valid && gnt0;
  assign hs1          = bus.s1_valid && gnt1;

  always_comb begin
    sel.sum  = {1'b0, bus.s0_a} + {1'b0, bus.s0_b};
    sel.id   = 1'b0;
    sel.last = bus.s0_last;
    if (hs1) begin
      sel.sum  = {1'b0, bus.s1_a} + {1'b0, bus.s1_b};
      sel.id   = 1'b1;
      sel.last = bus.s1_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr           <= 1'b1;
      busy_q       <= 1'b0;
      dout_q       <= '0;
      dout_id_q    <= 1'b0;
      dout_last_q  <= 1'b0;
      dout_valid_q <= 1'b0;
    end else if (hs0 || hs1) begin
      dout_q       <= sel.sum;
      dout_id_q    <= sel.id;
      dout_last_q  <= sel.last;
      dout_valid_q <= 1'b1;
      if (sel.last) begin
        rr     <= sel.id;
        state  <= IDLE;
        busy_q <= 1'b0;
      end else if (state == IDLE) begin
        state  <= sel.id ? LOCK1 : LOCK0;
        busy_q <= 1'b1;
      end
    end else if (bus.dout_ready) begin
      dout_valid_q <= 1'b0;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_id    = dout_id_q;
  assign bus.dout_last  = dout_last_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy_q;

endmodule

// File: doc/axi_add_arb.md
AXI_ADD_ARB -- requirements
Module: axi_add_arb

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand width of each addend.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- s0_a, s0_b  input  WIDTH  requester 0 operands
- s0_valid  input  1  requester 0 beat valid
- s0_last  input  1  requester 0 final beat of burst
- s0_ready  output  1  requester 0 beat accepted when high with s0_valid
- s1_a, s1_b, s1_valid, s1_last, s1_ready  as requester 0, for requester 1
- dout  output  WIDTH+1  registered sum
- dout_id  output  1  requester index of the beat in dout
- dout_last  output  1  copy of accepted beat's last flag
- dout_valid  output  1  dout holds an unconsumed result
- dout_ready  input  1  downstream accepts the result
- busy  output  1  high while a burst lock is held
REQ-003 Clock and reset SHALL be named clk and rst_n; reset SHALL be synchronous and active-low; there is one clock domain.

Function
REQ-004 out_free SHALL be (!dout_valid || dout_ready), evaluated combinationally.
REQ-005 The state machine SHALL have states IDLE, LOCK0 and LOCK1, plus a 1-bit round-robin pointer rr that holds the index of the last requester granted.
REQ-006 In IDLE with out_free, the grant SHALL go as follows:
- only one requester valid: that requester
- both valid: the requester != rr
- no requester valid: no grant
REQ-007 In LOCKx, only requester x SHALL be eligible, and the other requester's ready SHALL be 0 regardless of its valid.
REQ-008 sN_ready SHALL be high only when out_free is high and requester N is granted or eligible. Ready SHALL NOT depend on sN_valid except through the IDLE grant choice.
REQ-009 A handshake on requester N (sN_valid && sN_ready) SHALL, on the next edge:
- set dout to sN_a + sN_b, zero-extended to WIDTH+1 bits (no truncation; 8'hFF+8'hFF = 9'h1FE)
- set dout_id to N and dout_last to sN_last
- set dout_valid to 1
REQ-010 Without a handshake, if dout_ready is high, dout_valid SHALL clear to 0. Without a handshake, dout, dout_id and dout_last SHALL hold their values.
REQ-011 While dout_valid=1 and dout_ready=0, dout, dout_id, dout_last and dout_valid SHALL be stable and no requester SHALL see ready=1 (backpressure).
REQ-012 Latency SHALL be one cycle from handshake to dout_valid. At most one handshake SHALL occur per cycle.
REQ-013 Throughput SHALL be one beat per cycle when dout_ready is held high.
REQ-014 State transitions SHALL be:
- IDLE, handshake from x with last=0: go to LOCKx
- IDLE, handshake from x with last=1: stay in IDLE
- LOCKx, handshake with last=1: go to IDLE
- LOCKx, otherwise: stay in LOCKx
REQ-015 rr SHALL update to x on every handshake from x whose last=1, and SHALL be unchanged otherwise.
REQ-016 In LOCKx, a deasserted sx_valid SHALL NOT release the lock; the lock SHALL persist until the last beat is accepted.
REQ-017 busy SHALL equal (state != IDLE).

Reset
REQ-018 While rst_n=0 at a rising edge, the block SHALL set:
- state to IDLE, rr to 1 (requester 0 wins the first contest)
- dout to 0, dout_id to 0, dout_last to 0, dout_valid to 0
REQ-019 During reset, s0_ready and s1_ready SHALL evaluate from the post-reset state (IDLE, dout_valid=0).
REQ-020 A reset asserted mid-burst SHALL abandon the lock and discard any pending dout without completion.

Verification
REQ-021 Simultaneous single beats: s0=(3,4,last=1), s1=(10,20,last=1), dout_ready=1 after reset. Required response:
- cycle 1: s0 accepted, dout=7, id=0
- next cycle: s1 accepted, dout=30, id=1
REQ-022 Burst lock: s0 sends 3 beats (last on the third) while s1_valid is held high. Required response:
- s1_ready=0 and busy=1 throughout
- s1 accepted in the cycle after the third s0 beat
REQ-023 Backpressure: dout_ready=0 for 4 cycles after a beat with sum 9'h1FE (FF+FF). Required response:
- dout=9'h1FE and dout_valid=1 held stable
- both readies 0
- the next beat is accepted in the same cycle dout_ready rises
REQ-024 Bubble in a lock: s1 is in LOCK1 and drops s1_valid for 2 cycles while s0_valid=1. Required response: no s0 acceptance, state stays LOCK1.
REQ-025 Mid-burst reset: rst_n=0 for 1 cycle in LOCK0 with dout_valid=1. Required response:
- next cycle: dout_valid=0, busy=0
- then s1 wins a contest against s0 only if rr rules say so (rr=1, so s0 wins)
REQ-026 Streaming: dout_ready held 1 while s0 alone streams 8 single-beat transfers. Required response: 8 results on 8 consecutive cycles, dout_valid never drops between them.
